// File: rtl/brick_pkg.sv
// Shared constants, FSM state type and score helper
// for the brick map scorer.
package brick_pkg;

    localparam int N_COLS      = 20;
    localparam int N_ROWS      = 24;
    localparam int CELL_W      = 3;
    localparam int N_CELLS     = N_COLS * N_ROWS;
    localparam int MAP_W       = N_CELLS * CELL_W;
    localparam int PTS_PER_HIT = 10;
    localparam int SCORE_W     = 16;
    localparam int CNT_W       = 9;
    localparam int PTS_W       = 16;
    localparam int CELL_PTS_W  = 7;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_e;

    // Add in one extra bit and clamp to all-ones on carry out.
    function automatic logic [SCORE_W-1:0] sat_add(
        input logic [SCORE_W-1:0] a,
        input logic [PTS_W-1:0]   b
    );
        logic [SCORE_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[SCORE_W] ? {SCORE_W{1'b1}} : s[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/brick_map_scorer_cell_eval.sv
// Per-cell classification: alive, destroyed, and the points
// a destroyed cell is worth.
module brick_cell_eval
    import brick_pkg::*;
(
    input  logic [CELL_W-1:0]     p,
    input  logic [CELL_W-1:0]     n,
    output logic                  alive,
    output logic                  destroyed,
    output logic [CELL_PTS_W-1:0] pts
);

    // A cell that appears from nothing only counts as alive.
    always_comb begin
        alive     = (n != '0);
        destroyed = (p != '0) && (n == '0);
        pts       = '0;
        if (destroyed) begin
            pts = CELL_PTS_W'(p) * CELL_PTS_W'(PTS_PER_HIT);
        end
    end

endmodule

// File: rtl/brick_map_scorer.sv
// Snapshots a brick map pair, scans it one cell per clock
// and publishes destroyed/remaining counts and a running score.
module brick_map_scorer
    import brick_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [MAP_W-1:0]   bricks_prev,
    input  logic [MAP_W-1:0]   bricks_next,
    input  logic               score_clr,
    output logic               busy,
    output logic               done,
    output logic [CNT_W-1:0]   destroyed_cnt,
    output logic [CNT_W-1:0]   remaining,
    output logic [SCORE_W-1:0] score,
    output logic               level_clear
);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     idx_q, idx_d;
    logic [MAP_W-1:0]     prev_snap_q, prev_snap_d;
    logic [MAP_W-1:0]     next_snap_q, next_snap_d;
    logic [CNT_W-1:0]     w_destroyed_q, w_destroyed_d;
    logic [CNT_W-1:0]     w_alive_q, w_alive_d;
    logic [PTS_W-1:0]     w_pts_q, w_pts_d;
    logic [CNT_W-1:0]     destroyed_cnt_q, destroyed_cnt_d;
    logic [CNT_W-1:0]     remaining_q, remaining_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 level_clear_q, level_clear_d;

    logic [CELL_W-1:0]     cell_p;
    logic [CELL_W-1:0]     cell_n;
    logic                  cell_alive;
    logic                  cell_destroyed;
    logic [CELL_PTS_W-1:0] cell_pts;
    int unsigned           cell_base;

    // Select the cell under the scan pointer from both snapshots.
    always_comb begin
        cell_base = 32'(idx_q) * CELL_W;
        cell_p    = prev_snap_q[cell_base +: CELL_W];
        cell_n    = next_snap_q[cell_base +: CELL_W];
    end

    brick_cell_eval u_cell_eval (
        .p         (cell_p),
        .n         (cell_n),
        .alive     (cell_alive),
        .destroyed (cell_destroyed),
        .pts       (cell_pts)
    );

    // Next-state, accumulation and result publishing.
    // Results are loaded on the last scan edge so they are
    // already valid in the cycle that done is high.
    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        prev_snap_d     = prev_snap_q;
        next_snap_d     = next_snap_q;
        w_destroyed_d   = w_destroyed_q;
        w_alive_d       = w_alive_q;
        w_pts_d         = w_pts_q;
        destroyed_cnt_d = destroyed_cnt_q;
        remaining_d     = remaining_q;
        score_d         = score_q;
        level_clear_d   = level_clear_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    prev_snap_d   = bricks_prev;
                    next_snap_d   = bricks_next;
                    w_destroyed_d = '0;
                    w_alive_d     = '0;
                    w_pts_d       = '0;
                    idx_d         = '0;
                    state_d       = SCAN;
                end
            end
            SCAN: begin
                w_destroyed_d = w_destroyed_q + CNT_W'(cell_destroyed);
                w_alive_d     = w_alive_q + CNT_W'(cell_alive);
                w_pts_d       = w_pts_q + PTS_W'(cell_pts);
                if (idx_q == CNT_W'(N_CELLS - 1)) begin
                    destroyed_cnt_d = w_destroyed_d;
                    remaining_d     = w_alive_d;
                    level_clear_d   = (w_alive_d == '0);
                    score_d         = sat_add(score_q, w_pts_d);
                    state_d         = DONE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (score_clr) begin
            score_d = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            prev_snap_q     <= '0;
            next_snap_q     <= '0;
            w_destroyed_q   <= '0;
            w_alive_q       <= '0;
            w_pts_q         <= '0;
            destroyed_cnt_q <= '0;
            remaining_q     <= '0;
            score_q         <= '0;
            level_clear_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            prev_snap_q     <= prev_snap_d;
            next_snap_q     <= next_snap_d;
            w_destroyed_q   <= w_destroyed_d;
            w_alive_q       <= w_alive_d;
            w_pts_q         <= w_pts_d;
            destroyed_cnt_q <= destroyed_cnt_d;
            remaining_q     <= remaining_d;
            score_q         <= score_d;
            level_clear_q   <= level_clear_d;
        end
    end

    assign busy          = (state_q != IDLE);
    assign done          = (state_q == DONE);
    assign destroyed_cnt = destroyed_cnt_q;
    assign remaining     = remaining_q;
    assign score         = score_q;
    assign level_clear   = level_clear_q;

endmodule
